// File: rtl/tv80_bus_pkg.sv
// Shared definitions for the tv80 bus bridge: FSM state encoding and
// default parameter values.
package tv80_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } bridge_state_e;

  localparam logic [7:0] INT_VECTOR_DEFAULT = 8'hFF;
  localparam int         TIMEOUT_DEFAULT    = 255;
  localparam int         TO_W_DEFAULT       = 8;

endpackage

// File: rtl/tv80_bus_bridge.sv
// Bridges tv80 CPU bus cycles onto a single-outstanding req/ack target port,
// stretching the CPU with wait states until the target (or a timeout) completes.
module tv80_bus_bridge
  import tv80_bus_pkg::*;
#(
  parameter logic [7:0] INT_VECTOR = INT_VECTOR_DEFAULT,
  parameter int         TIMEOUT    = TIMEOUT_DEFAULT,
  parameter int         TO_W       = TO_W_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        rfsh_n,
  input  logic [15:0] A,
  input  logic [7:0]  dout,
  output logic [7:0]  di,
  output logic        wait_n,
  output logic        tgt_req,
  output logic        tgt_we,
  output logic        tgt_io,
  output logic [15:0] tgt_addr,
  output logic [7:0]  tgt_wdata,
  input  logic [7:0]  tgt_rdata,
  input  logic        tgt_ack,
  output logic        bus_err
);

  localparam bit              TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  bridge_state_e   state_q, state_d;
  logic [7:0]      di_q, di_d;
  logic            tgt_req_q, tgt_req_d;
  logic            tgt_we_q, tgt_we_d;
  logic            tgt_io_q, tgt_io_d;
  logic [15:0]     tgt_addr_q, tgt_addr_d;
  logic [7:0]      tgt_wdata_q, tgt_wdata_d;
  logic            bus_err_q, bus_err_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            acc_s, inta_s;

  // Decode of the CPU strobes; refresh and interrupt-acknowledge are excluded from acc.
  always_comb begin
    acc_s  = ((~mreq_n & rfsh_n) | (~iorq_n & m1_n)) & (~rd_n | ~wr_n);
    inta_s = ~iorq_n & ~m1_n;
  end

  // Next-state logic: one target transaction per CPU bus cycle.
  always_comb begin
    state_d     = state_q;
    di_d        = di_q;
    tgt_req_d   = tgt_req_q;
    tgt_we_d    = tgt_we_q;
    tgt_io_d    = tgt_io_q;
    tgt_addr_d  = tgt_addr_q;
    tgt_wdata_d = tgt_wdata_q;
    bus_err_d   = bus_err_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (inta_s) begin
          di_d    = INT_VECTOR;
          state_d = DONE;
        end else if (acc_s) begin
          tgt_addr_d  = A;
          tgt_wdata_d = dout;
          tgt_we_d    = ~wr_n;
          tgt_io_d    = ~iorq_n;
          tgt_req_d   = 1'b1;
          cnt_d       = {TO_W{1'b0}};
          state_d     = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        cnt_d = cnt_q + TO_W'(1);
        // Ack has priority over a timeout landing in the same cycle.
        if (tgt_ack) begin
          tgt_req_d = 1'b0;
          di_d      = tgt_we_q ? di_q : tgt_rdata;
          state_d   = DONE;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          tgt_req_d = 1'b0;
          di_d      = 8'hFF;
          bus_err_d = 1'b1;
          state_d   = DONE;
        end else begin
          state_d = REQ;
        end
      end
      DONE: begin
        if (!acc_s && !inta_s) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d   = IDLE;
        tgt_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      di_q        <= 8'hFF;
      tgt_req_q   <= 1'b0;
      tgt_we_q    <= 1'b0;
      tgt_io_q    <= 1'b0;
      tgt_addr_q  <= 16'h0000;
      tgt_wdata_q <= 8'h00;
      bus_err_q   <= 1'b0;
      cnt_q       <= {TO_W{1'b0}};
    end else begin
      state_q     <= state_d;
      di_q        <= di_d;
      tgt_req_q   <= tgt_req_d;
      tgt_we_q    <= tgt_we_d;
      tgt_io_q    <= tgt_io_d;
      tgt_addr_q  <= tgt_addr_d;
      tgt_wdata_q <= tgt_wdata_d;
      bus_err_q   <= bus_err_d;
      cnt_q       <= cnt_d;
    end
  end

  // wait_n must drop in the very cycle the strobes appear, so it cannot be registered.
  always_comb begin
    if (!reset_n) begin
      wait_n = 1'b1;
    end else begin
      wait_n = ~((acc_s | inta_s) & (state_q != DONE));
    end
  end

  assign di        = di_q;
  assign tgt_req   = tgt_req_q;
  assign tgt_we    = tgt_we_q;
  assign tgt_io    = tgt_io_q;
  assign tgt_addr  = tgt_addr_q;
  assign tgt_wdata = tgt_wdata_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_tv80_bus_bridge.sv
// Self-checking bench for tv80_bus_bridge: directed vector table, reset corner
// cases and randomized accesses against a transaction-level reference model.
module tb_tv80_bus_bridge;

  localparam int TO = 4;
  localparam int K_MEMRD = 0, K_MEMWR = 1, K_IORD = 2, K_IOWR = 3,
                 K_INTA = 4, K_M1 = 5, K_RFSH = 6;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
  logic [15:0] A;
  logic [7:0]  dout, di, tgt_wdata, tgt_rdata;
  logic        wait_n, tgt_req, tgt_we, tgt_io, tgt_ack, bus_err;
  logic [15:0] tgt_addr;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic [7:0]  wd;
    int          ack;
    logic [7:0]  rd;
    int          e_req;
    int          e_waits;
    logic [7:0]  e_di;
    logic        e_err;
  } vec_t;

  typedef struct {
    int          req_cyc;
    int          req_edges;
    int          waits;
    logic [7:0]  di;
    logic [15:0] addr;
    logic        we;
    logic        io;
    logic [7:0]  wdata;
    logic        drift;
    logic        hung;
  } obs_t;

  vec_t tbl[9];

  tv80_bus_bridge #(.INT_VECTOR(8'hFF), .TIMEOUT(TO), .TO_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n),
    .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n), .A(A), .dout(dout), .di(di),
    .wait_n(wait_n), .tgt_req(tgt_req), .tgt_we(tgt_we), .tgt_io(tgt_io),
    .tgt_addr(tgt_addr), .tgt_wdata(tgt_wdata), .tgt_rdata(tgt_rdata),
    .tgt_ack(tgt_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_strobes(input int kind);
    {m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n} = 6'b111111;
    case (kind)
      K_MEMRD: begin mreq_n = 1'b0; rd_n = 1'b0; end
      K_MEMWR: begin mreq_n = 1'b0; wr_n = 1'b0; end
      K_IORD:  begin iorq_n = 1'b0; rd_n = 1'b0; end
      K_IOWR:  begin iorq_n = 1'b0; wr_n = 1'b0; end
      K_INTA:  begin iorq_n = 1'b0; m1_n = 1'b0; end
      K_M1:    begin m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0; end
      K_RFSH:  begin mreq_n = 1'b0; rfsh_n = 1'b0; end
      default: ;
    endcase
  endtask

  // Acts as CPU (holds strobes while wait_n is low) and as target (acks after
  // v.ack request cycles, never if 0). Entered and left just after a posedge.
  task automatic run_access(input vec_t v, output obs_t o);
    logic done = 1'b0;
    logic prev = 1'b0;
    o = '{default: '0};
    A = v.addr;
    dout = v.wd;
    set_strobes(v.kind);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      tgt_ack = 1'b0;
      tgt_rdata = 8'($urandom);
      if (tgt_req) begin
        o.req_cyc++;
        if (!prev) o.req_edges++;
        if (o.req_cyc == 1) begin
          o.addr = tgt_addr; o.we = tgt_we; o.io = tgt_io; o.wdata = tgt_wdata;
        end else if (tgt_addr !== o.addr || tgt_wdata !== o.wdata) begin
          o.drift = 1'b1;
        end
        if (o.req_cyc == v.ack) begin
          tgt_ack = 1'b1;
          tgt_rdata = v.rd;
        end
      end
      prev = tgt_req;
      if (!wait_n) o.waits++;
      else begin
        o.di = di;
        done = 1'b1;
      end
      @(posedge clk); #1;
      A = 16'($urandom);
      dout = 8'($urandom);
    end
    o.hung = !done;
    tgt_ack = 1'b0;
    set_strobes(-1);
  endtask

  task automatic check_access(input string tag, input vec_t v);
    obs_t o;
    logic is_wr, is_io;
    run_access(v, o);
    is_wr = (v.kind == K_MEMWR) || (v.kind == K_IOWR);
    is_io = (v.kind == K_IORD) || (v.kind == K_IOWR);
    chk({tag, " completes"}, 32'(o.hung), 32'd0);
    chk({tag, " req cycles"}, 32'(o.req_cyc), 32'(v.e_req));
    chk({tag, " req count"}, 32'(o.req_edges), (v.e_req > 0) ? 32'd1 : 32'd0);
    chk({tag, " wait states"}, 32'(o.waits), 32'(v.e_waits));
    chk({tag, " di"}, 32'(o.di), 32'(v.e_di));
    if (v.e_req > 0) begin
      chk({tag, " tgt_addr"}, 32'(o.addr), 32'(v.addr));
      chk({tag, " tgt_we"}, 32'(o.we), 32'(is_wr));
      chk({tag, " tgt_io"}, 32'(o.io), 32'(is_io));
      chk({tag, " addr/data stable"}, 32'(o.drift), 32'd0);
      if (is_wr) chk({tag, " tgt_wdata"}, 32'(o.wdata), 32'(v.wd));
    end
    // Idle gap with a stray ack that must be ignored.
    @(negedge clk);
    tgt_ack = 1'($urandom);
    chk({tag, " gap wait_n"}, 32'(wait_n), 32'd1);
    chk({tag, " gap tgt_req"}, 32'(tgt_req), 32'd0);
    @(posedge clk); #1;
    tgt_ack = 1'b0;
    @(negedge clk);
    chk({tag, " bus_err"}, 32'(bus_err), 32'(v.e_err));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] di_m;
    logic       err_m;
    vec_t       v;
    logic       acked;

    //              kind     addr      wd     ack rd     req wt di     err
    tbl[0] = '{K_MEMRD, 16'h1234, 8'h00, 3, 8'h5A, 3, 4, 8'h5A, 1'b0};
    tbl[1] = '{K_MEMWR, 16'h6800, 8'h21, 1, 8'h99, 1, 2, 8'h5A, 1'b0};
    tbl[2] = '{K_IORD,  16'h00FE, 8'h00, 2, 8'hBF, 2, 3, 8'hBF, 1'b0};
    tbl[3] = '{K_INTA,  16'h0000, 8'h00, 1, 8'h11, 0, 1, 8'hFF, 1'b0};
    tbl[4] = '{K_M1,    16'h0038, 8'h00, 1, 8'hC3, 1, 2, 8'hC3, 1'b0};
    tbl[5] = '{K_RFSH,  16'h0042, 8'h00, 1, 8'h22, 0, 0, 8'hC3, 1'b0};
    tbl[6] = '{K_IOWR,  16'h0010, 8'h77, 4, 8'h00, 4, 5, 8'hC3, 1'b0};
    tbl[7] = '{K_MEMRD, 16'h2000, 8'h00, 0, 8'h00, 4, 5, 8'hFF, 1'b1};
    tbl[8] = '{K_MEMRD, 16'h2001, 8'h00, 1, 8'h3C, 1, 2, 8'h3C, 1'b1};

    reset_n = 1'b0;
    tgt_ack = 1'b0;
    tgt_rdata = 8'h00;
    A = 16'h0000;
    dout = 8'h00;
    set_strobes(K_MEMRD);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset wait_n forced high", 32'(wait_n), 32'd1);
    chk("reset di", 32'(di), 32'hFF);
    chk("reset tgt_req", 32'(tgt_req), 32'd0);
    chk("reset bus_err", 32'(bus_err), 32'd0);
    chk("reset tgt_addr", 32'(tgt_addr), 32'd0);
    chk("reset tgt_we/io/wdata", {22'd0, tgt_we, tgt_io, tgt_wdata}, 32'd0);
    set_strobes(-1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) check_access($sformatf("vec%0d", i), tbl[i]);

    // Reset in the middle of a request: everything drops at once, late ack ignored.
    A = 16'hABCD;
    set_strobes(K_MEMRD);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midreq tgt_req before reset", 32'(tgt_req), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("midreq tgt_req after reset", 32'(tgt_req), 32'd0);
    chk("midreq bus_err after reset", 32'(bus_err), 32'd0);
    chk("midreq wait_n after reset", 32'(wait_n), 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    set_strobes(-1);
    tgt_ack = 1'b1;
    tgt_rdata = 8'h66;
    @(negedge clk);
    chk("late ack tgt_req", 32'(tgt_req), 32'd0);
    chk("late ack wait_n", 32'(wait_n), 32'd1);
    @(posedge clk); #1;
    tgt_ack = 1'b0;
    @(negedge clk);
    chk("late ack di", 32'(di), 32'hFF);
    chk("late ack tgt_req stays low", 32'(tgt_req), 32'd0);
    @(posedge clk); #1;

    // Randomized accesses against a transaction-level model.
    di_m = 8'hFF;
    err_m = 1'b0;
    for (int i = 0; i < 40; i++) begin
      v.kind = int'($urandom_range(0, 6));
      v.addr = 16'($urandom);
      v.wd   = 8'($urandom);
      v.ack  = int'($urandom_range(0, 5));
      v.rd   = 8'($urandom);
      if (v.kind == K_INTA) begin
        v.e_req = 0; v.e_waits = 1; v.e_di = 8'hFF;
      end else if (v.kind == K_RFSH) begin
        v.e_req = 0; v.e_waits = 0; v.e_di = di_m;
      end else begin
        acked = (v.ack >= 1) && (v.ack <= TO);
        v.e_req = acked ? v.ack : TO;
        v.e_waits = v.e_req + 1;
        if (!acked) begin
          v.e_di = 8'hFF;
          err_m = 1'b1;
        end else if (v.kind == K_MEMWR || v.kind == K_IOWR) begin
          v.e_di = di_m;
        end else begin
          v.e_di = v.rd;
        end
      end
      di_m = v.e_di;
      v.e_err = err_m;
      check_access($sformatf("rnd%0d", i), v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
